proc_core_p: RTL and testbench

Parametrised second-generation multicycle processor core. Generalises the 9-bit, 8-register add/sub machine in data width and memory addressing. R7 acts as the program counter, and the core fetches its own instructions over a req/ack memory port that tolerates wait states. Adds ld, st, mvnz and and instructions. Sits between the system top level and a synchronous ROM/RAM wrapper.

---
 rtl/proc_core_pkg.sv | 29 ++
 rtl/proc_core_if.sv | 25 ++
 rtl/proc_alu.sv | 26 ++
 rtl/proc_core_p.sv | 157 +++++++++++++++
 tb/tb_proc_core_p.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_core_pkg.sv
// Shared types and instruction-field positions for the multicycle core.
// Field LSBs are given as offsets down from the top of the word, so they hold for any DATA_W >= 9.
package proc_core_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_AND  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, IMM, ALU, WB, MEM, DONE
  } state_e;

  localparam int FIELD_W = 9;
  localparam int OP_OFS  = 3;
  localparam int X_OFS   = 6;
  localparam int Y_OFS   = 9;

  function automatic int field_lsb(input int data_w, input int ofs);
    return data_w - ofs;
  endfunction

endpackage

// File: rtl/proc_core_if.sv
// Core-to-memory request port: mem_req is held until mem_ack, which also qualifies mem_rdata.
// The master keeps address, direction and write data stable while waiting.
interface proc_core_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/proc_alu.sv
// Combinational add/sub/and with zero detect; result is used in the same cycle.
// Any opcode other than sub/and computes the sum.
module proc_alu
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              zero_o
);

  always_comb begin
    res_o = a_i + b_i;
    case (op_i)
      OP_SUB:  res_o = a_i + ~b_i + 1'b1;
      OP_AND:  res_o = a_i & b_i;
      default: res_o = a_i + b_i;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/proc_core_p.sv
// Multicycle core, R7 = PC, fetching over a req/ack port: 3-5 cycles per instruction plus one per wait.
// A pending memory request stalls the FSM in FETCH/IMM/MEM with its request fields held.
module proc_core_p
  import proc_core_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  proc_core_if.master       bus,
  output logic              done,
  output logic [DATA_W-1:0] ir_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              zero_o
);

  localparam int OP_LSB = field_lsb(DATA_W, OP_OFS);
  localparam int X_LSB  = field_lsb(DATA_W, X_OFS);
  localparam int Y_LSB  = field_lsb(DATA_W, Y_OFS);

  state_e            state_q;
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] a_q, g_q, ir_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              zero_q, req_q, we_q, done_q;

  opcode_e           op;
  logic [2:0]        rx, ry;
  logic [DATA_W-1:0] pc_inc_d, alu_res_d;
  logic              alu_zero_d;

  assign op       = opcode_e'(ir_q[OP_LSB +: 3]);
  assign rx       = ir_q[X_LSB +: 3];
  assign ry       = ir_q[Y_LSB +: 3];
  assign pc_inc_d = r_q[7] + 1'b1;

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (op),
    .a_i   (a_q),
    .b_i   (r_q[ry]),
    .res_o (alu_res_d),
    .zero_o(alu_zero_d)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      a_q     <= '0;
      g_q     <= '0;
      ir_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      zero_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= r_q[7][ADDR_W-1:0];
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            ir_q    <= bus.mem_rdata;
            r_q[7]  <= pc_inc_d;
            req_q   <= 1'b0;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          case (op)
            OP_MV, OP_MVNZ: begin
              if (op == OP_MV || !zero_q) r_q[rx] <= r_q[ry];
              done_q  <= 1'b1;
              state_q <= DONE;
            end
            OP_MVI: begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= r_q[7][ADDR_W-1:0];
              state_q <= IMM;
            end
            OP_LD, OP_ST: begin
              req_q   <= 1'b1;
              we_q    <= (op == OP_ST);
              addr_q  <= r_q[ry][ADDR_W-1:0];
              wdata_q <= r_q[rx];
              state_q <= MEM;
            end
            default: begin
              a_q     <= r_q[rx];
              state_q <= ALU;
            end
          endcase
        end
        IMM: begin
          if (bus.mem_ack) begin
            // Order matters: mvi R7 must land the immediate, not PC+1.
            r_q[7]  <= pc_inc_d;
            r_q[rx] <= bus.mem_rdata;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        ALU: begin
          g_q     <= alu_res_d;
          zero_q  <= alu_zero_d;
          state_q <= WB;
        end
        WB: begin
          r_q[rx] <= g_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        MEM: begin
          if (bus.mem_ack) begin
            if (!we_q) r_q[rx] <= bus.mem_rdata;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (run) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= r_q[7][ADDR_W-1:0];
            state_q <= FETCH;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = done_q;
  assign ir_o          = ir_q;
  assign pc_o          = r_q[7];
  assign zero_o        = zero_q;

endmodule

// File: tb/tb_proc_core_p.sv
// Bench for proc_core_p: 9-bit and 16-bit instances, memory responder with wait states,
// and an instruction-level reference model stepped once per executed instruction.
module tb_proc_core_p;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        t_run = 1'b0;
  logic        t_ack = 1'b0;
  logic [31:0] t_rdata = '0;
  logic        sel16 = 1'b0;

  always #5 clk = ~clk;

  proc_core_if #(.DATA_W(9),  .ADDR_W(5)) if9 ();
  proc_core_if #(.DATA_W(16), .ADDR_W(8)) if16 ();

  logic        done9, done16, z9, z16, run9, run16;
  logic [8:0]  ir9, pc9;
  logic [15:0] ir16, pc16;

  assign run9           = t_run & ~sel16;
  assign run16          = t_run & sel16;
  assign if9.mem_ack    = t_ack & ~sel16;
  assign if9.mem_rdata  = t_rdata[8:0];
  assign if16.mem_ack   = t_ack & sel16;
  assign if16.mem_rdata = t_rdata[15:0];

  proc_core_p #(.DATA_W(9), .ADDR_W(5)) dut9 (
    .clk(clk), .resetn(resetn), .run(run9), .bus(if9),
    .done(done9), .ir_o(ir9), .pc_o(pc9), .zero_o(z9)
  );

  proc_core_p #(.DATA_W(16), .ADDR_W(8)) dut16 (
    .clk(clk), .resetn(resetn), .run(run16), .bus(if16),
    .done(done16), .ir_o(ir16), .pc_o(pc16), .zero_o(z16)
  );

  logic        c_req, c_we, c_done, c_z;
  logic [31:0] c_addr, c_wdata, c_ir, c_pc;

  always_comb begin
    if (sel16) begin
      c_req = if16.mem_req; c_we = if16.mem_we; c_done = done16; c_z = z16;
      c_addr = 32'(if16.mem_addr); c_wdata = 32'(if16.mem_wdata);
      c_ir = 32'(ir16); c_pc = 32'(pc16);
    end else begin
      c_req = if9.mem_req; c_we = if9.mem_we; c_done = done9; c_z = z9;
      c_addr = 32'(if9.mem_addr); c_wdata = 32'(if9.mem_wdata);
      c_ir = 32'(ir9); c_pc = 32'(pc9);
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural registers and its own copy of memory.
  int          gw, gaw;
  logic [31:0] mask, amask;
  logic [31:0] m  [256];
  logic [31:0] rm [256];
  logic [31:0] rr [8];
  logic        rz;

  logic [31:0] e_ir, e_pc;
  logic        e_z;
  int          e_lat, e_n, d_n;
  logic [31:0] e_addr [3], e_wd [3], d_addr [3], d_wd [3];
  logic        e_we [3], d_we [3];

  int          lat_hist [64];
  logic [31:0] fa_hist [64];
  logic        zh [64];

  function automatic logic [31:0] enc(input int op, input int x, input int y);
    return 32'((op << 6) | (x << 3) | y) << (gw - 9);
  endfunction

  task automatic exp_acc(input logic [31:0] a, input logic w, input logic [31:0] d);
    e_addr[e_n] = a; e_we[e_n] = w; e_wd[e_n] = d; e_n++;
  endtask

  task automatic iss_step();
    logic [31:0] ir, a, res;
    int op, x, y;
    e_n = 0;
    a   = rr[7] & amask;
    ir  = rm[a];
    exp_acc(a, 1'b0, 32'd0);
    rr[7] = (rr[7] + 1) & mask;
    op = int'((ir >> (gw - 3)) & 32'd7);
    x  = int'((ir >> (gw - 6)) & 32'd7);
    y  = int'((ir >> (gw - 9)) & 32'd7);
    e_lat = 3;
    case (op)
      0: rr[x] = rr[y];
      6: if (!rz) rr[x] = rr[y];
      1: begin
        a = rr[7] & amask;
        exp_acc(a, 1'b0, 32'd0);
        rr[7] = (rr[7] + 1) & mask;
        rr[x] = rm[a];
        e_lat = 4;
      end
      4: begin
        a = rr[y] & amask;
        exp_acc(a, 1'b0, 32'd0);
        rr[x] = rm[a];
        e_lat = 4;
      end
      5: begin
        a = rr[y] & amask;
        exp_acc(a, 1'b1, rr[x]);
        rm[a] = rr[x];
        e_lat = 4;
      end
      default: begin
        if (op == 2)      res = rr[x] + rr[y];
        else if (op == 3) res = rr[x] - rr[y];
        else              res = rr[x] & rr[y];
        res   = res & mask;
        rz    = (res == 0);
        rr[x] = res;
        e_lat = 5;
      end
    endcase
    e_ir = ir; e_pc = rr[7]; e_z = rz;
  endtask

  task automatic do_reset(input logic wide);
    @(negedge clk);
    sel16 = wide; resetn = 1'b0; t_run = 1'b0; t_ack = 1'b0;
    gw = wide ? 16 : 9;
    gaw = wide ? 8 : 5;
    mask = (32'd1 << gw) - 1;
    amask = (32'd1 << gaw) - 1;
    for (int i = 0; i < 8; i++) rr[i] = '0;
    rz = 1'b0;
    for (int i = 0; i < 256; i++) begin m[i] = '0; rm[i] = '0; end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic ldw(input int a, input logic [31:0] v);
    m[a] = v & mask; rm[a] = v & mask;
  endtask

  // Runs n instructions; run is dropped as the last one starts, so the core must finish it and idle.
  task automatic run_prog(input int n, input int wmode);
    int dn, cyc, wt, wcnt, waits, guard;
    logic started, holding, h_we, busy;
    logic [31:0] h_addr, h_wd;
    dn = 0; cyc = 0; wt = 0; wcnt = 0; waits = 0; guard = 0;
    started = 0; holding = 0; h_we = 0; h_addr = 0; h_wd = 0;
    t_run = 1'b1;
    while (dn < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      t_ack = 1'b0;
      if (started) cyc++;
      if (c_req) begin
        if (!started) begin
          started = 1; cyc = 1; waits = 0; d_n = 0;
          fa_hist[dn] = c_addr;
          iss_step();
          if (dn == n - 1) t_run = 1'b0;
        end
        if (!holding) begin
          holding = 1; wcnt = 0;
          wt = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
          waits += wt;
          h_addr = c_addr; h_we = c_we; h_wd = c_wdata;
        end else begin
          checks++;
          if ({c_addr, c_we, c_wdata} !== {h_addr, h_we, h_wd}) begin
            errors++;
            $display("FAIL hold instr %0d: addr/we/wdata %h/%b/%h want %h/%b/%h",
                     dn, c_addr, c_we, c_wdata, h_addr, h_we, h_wd);
          end
        end
        if (wcnt == wt) begin
          t_ack = 1'b1;
          if (c_we) m[c_addr] = c_wdata & mask;
          else      t_rdata = m[c_addr];
          if (d_n < 3) begin
            d_addr[d_n] = c_addr; d_we[d_n] = c_we; d_wd[d_n] = c_wdata;
          end
          d_n++;
          holding = 0;
        end else begin
          wcnt++;
        end
      end
      if (c_done) begin
        checks++;
        if (c_ir !== e_ir) begin
          errors++; $display("FAIL ir instr %0d: got %h want %h", dn, c_ir, e_ir);
        end
        checks++;
        if (c_pc !== e_pc) begin
          errors++; $display("FAIL pc instr %0d: got %h want %h", dn, c_pc, e_pc);
        end
        checks++;
        if (c_z !== e_z) begin
          errors++; $display("FAIL zero instr %0d: got %b want %b", dn, c_z, e_z);
        end
        checks++;
        if (cyc != e_lat + waits) begin
          errors++; $display("FAIL latency instr %0d: got %0d want %0d", dn, cyc, e_lat + waits);
        end
        checks++;
        if (d_n != e_n) begin
          errors++; $display("FAIL access count instr %0d: got %0d want %0d", dn, d_n, e_n);
        end
        for (int i = 0; i < e_n && i < d_n; i++) begin
          checks++;
          if (d_addr[i] !== e_addr[i] || d_we[i] !== e_we[i] || (e_we[i] && d_wd[i] !== e_wd[i])) begin
            errors++;
            $display("FAIL access instr %0d.%0d: addr/we/wdata %h/%b/%h want %h/%b/%h",
                     dn, i, d_addr[i], d_we[i], d_wd[i], e_addr[i], e_we[i], e_wd[i]);
          end
        end
        lat_hist[dn] = cyc;
        zh[dn] = c_z;
        dn++;
        started = 0;
      end
    end
    checks++;
    if (dn < n) begin
      errors++; $display("FAIL timeout: %0d of %0d instructions completed", dn, n);
    end
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      busy = busy | c_req | c_done;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle after run drop: activity %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({c_req, c_we, c_done, c_z, c_addr, c_wdata, c_ir, c_pc} !== '0) begin
      errors++;
      $display("FAIL reset outputs: req=%b we=%b done=%b z=%b addr=%h wd=%h ir=%h pc=%h want all 0",
               c_req, c_we, c_done, c_z, c_addr, c_wdata, c_ir, c_pc);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (c_req !== 1'b0) begin
      errors++; $display("FAIL idle without run: req=%b want 0", c_req);
    end
    t_run = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_req, c_we, c_addr} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL first fetch: req=%b we=%b addr=%h want 1/0/0", c_req, c_we, c_addr);
    end
    t_run = 1'b0;
  endtask

  task automatic test_add();
    do_reset(1'b0);
    ldw(0, enc(1, 0, 0)); ldw(1, 5);
    ldw(2, enc(1, 1, 0)); ldw(3, 3);
    ldw(4, enc(2, 0, 1));
    ldw(5, enc(1, 2, 0)); ldw(6, 20);
    ldw(7, enc(5, 0, 2));
    run_prog(5, 0);
    checks++;
    if (m[20] !== 32'd8) begin errors++; $display("FAIL add result: got %h want 8", m[20]); end
    checks++;
    if (lat_hist[2] != 5) begin errors++; $display("FAIL add latency: got %0d want 5", lat_hist[2]); end
    checks++;
    if (zh[2] !== 1'b0) begin errors++; $display("FAIL add zero: got %b want 0", zh[2]); end
  endtask

  task automatic test_mvnz_and();
    do_reset(1'b0);
    ldw(0, enc(1, 2, 0)); ldw(1, 10);
    ldw(2, enc(1, 0, 0)); ldw(3, 7);
    ldw(4, enc(3, 0, 0));
    ldw(5, enc(6, 7, 2));
    ldw(6, enc(1, 3, 0)); ldw(7, 6);
    ldw(8, enc(7, 3, 3));
    ldw(9, enc(6, 7, 2));
    ldw(10, enc(1, 4, 0)); ldw(11, 25);
    ldw(12, enc(5, 3, 4));
    run_prog(9, -1);
    checks++;
    if (zh[2] !== 1'b1) begin errors++; $display("FAIL sub zero: got %b want 1", zh[2]); end
    checks++;
    if (fa_hist[4] !== 32'd6) begin errors++; $display("FAIL mvnz no-jump fetch: got %h want 6", fa_hist[4]); end
    checks++;
    if (zh[5] !== 1'b0) begin errors++; $display("FAIL and zero: got %b want 0", zh[5]); end
    checks++;
    if (fa_hist[7] !== 32'd10) begin errors++; $display("FAIL mvnz jump fetch: got %h want a", fa_hist[7]); end
    checks++;
    if (m[25] !== 32'd6) begin errors++; $display("FAIL and result: got %h want 6", m[25]); end
  endtask

  task automatic test_ld_st();
    do_reset(1'b0);
    ldw(0, enc(1, 7, 0)); ldw(1, 16);
    ldw(16, enc(1, 3, 0)); ldw(17, 32'h1AB);
    ldw(18, enc(1, 4, 0)); ldw(19, 6);
    ldw(20, enc(5, 3, 4));
    ldw(21, enc(4, 5, 4));
    ldw(22, enc(1, 6, 0)); ldw(23, 30);
    ldw(24, enc(5, 5, 6));
    run_prog(7, 3);
    checks++;
    if (m[6] !== 32'h1AB) begin errors++; $display("FAIL st data: got %h want 1ab", m[6]); end
    checks++;
    if (m[30] !== 32'h1AB) begin errors++; $display("FAIL ld data: got %h want 1ab", m[30]); end
    checks++;
    if (lat_hist[3] != 10 || lat_hist[4] != 10) begin
      errors++; $display("FAIL st/ld latency: got %0d/%0d want 10/10", lat_hist[3], lat_hist[4]);
    end
  endtask

  task automatic test_wide16();
    do_reset(1'b1);
    ldw(0, enc(1, 0, 0)); ldw(1, 32'hFFFF);
    ldw(2, enc(1, 1, 0)); ldw(3, 1);
    ldw(4, enc(2, 0, 1));
    ldw(5, enc(1, 2, 0)); ldw(6, 200);
    ldw(7, enc(5, 0, 2));
    ldw(8, enc(1, 7, 0)); ldw(9, 32'hFFFF);
    ldw(255, enc(0, 3, 3));
    ldw(200, 32'h1234);
    run_prog(7, -1);
    checks++;
    if (m[200] !== 32'd0) begin errors++; $display("FAIL wide add: got %h want 0", m[200]); end
    checks++;
    if (zh[2] !== 1'b1) begin errors++; $display("FAIL wide zero: got %b want 1", zh[2]); end
    checks++;
    if (fa_hist[6] !== 32'hFF) begin errors++; $display("FAIL wide fetch addr: got %h want ff", fa_hist[6]); end
    checks++;
    if (c_pc !== 32'd0) begin errors++; $display("FAIL pc wrap: got %h want 0", c_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    ldw(0, enc(1, 0, 0)); ldw(1, 5);
    run_prog(1, 0);
    t_run = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({c_req, c_addr, c_pc} !== {1'b1, 32'd2, 32'd2}) begin
      errors++; $display("FAIL pending fetch: req=%b addr=%h pc=%h want 1/2/2", c_req, c_addr, c_pc);
    end
    resetn = 1'b0; t_run = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_req, c_pc, c_ir} !== {1'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL reset mid-request: req=%b pc=%h ir=%h want 0/0/0", c_req, c_pc, c_ir);
    end
    resetn = 1'b1;
    t_ack = 1'b1; t_rdata = enc(1, 7, 0);
    @(negedge clk);
    t_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_req, c_done, c_pc, c_ir} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL late ack: req=%b done=%b pc=%h ir=%h want 0/0/0/0", c_req, c_done, c_pc, c_ir);
    end
  endtask

  task automatic test_random();
    int a, ni, op, x, y;
    for (int it = 0; it < 3; it++) begin
      do_reset(1'b0);
      for (int i = 24; i < 32; i++) ldw(i, $urandom);
      ldw(0, enc(1, 6, 0)); ldw(1, 24 + $urandom_range(0, 7));
      a = 2; ni = 1;
      while (a < 20) begin
        op = int'($urandom_range(0, 7));
        x  = int'($urandom_range(0, 5));
        y  = (op == 4 || op == 5) ? 6 : int'($urandom_range(0, 6));
        ldw(a, enc(op, x, y));
        a++;
        if (op == 1) begin ldw(a, $urandom); a++; end
        ni++;
      end
      run_prog(ni, -1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mvnz_and();
    test_ld_st();
    test_wide16();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
